truth_table_sweeper: RTL and testbench
======================================

Name: truth_table_sweeper

Overview:
- Sequential stimulus/capture stage wrapped around a 3-input combinational boolean block (a, b, c -> x).
- Drives all eight {a,b,c} input vectors into the block, in order, and samples the returned x after a programmable settle time.
- Assembles the eight samples into an 8-bit truth table and compares it with an expected pattern.
- Reports busy, done and pass to the lab top level, which shows them on LEDs.

Parameters:
- EXPECTED, 8'h57: expected truth table, bit i = x for {a,b,c}=i. 8'h57 encodes x = (~a&~b)|~c.
- SETTLE, 2: cycles each vector is held before x is sampled. Legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  level sampled each clk; begins a sweep when accepted.
- x_in  input  1  output x of the function block under test.
- a_out  output  1  vector bit 2 to the function block.
- b_out  output  1  vector bit 1 to the function block.
- c_out  output  1  vector bit 0 to the function block.
- busy  output  1  high while a sweep is in progress.
- done  output  1  high from sweep completion until the next accepted start or rst.
- pass  output  1  valid while done; 1 = captured table == EXPECTED.
- table_out  output  8  captured truth table, bit i = sample for vector i.
- mismatch_cnt  output  4  number of vectors whose sample differed from EXPECTED (0..8).

Behaviour:
- Reset:
  - rst asserted (asynchronous, active-high) forces state=IDLE.
  - idx=0, settle counter=0.
  - a_out/b_out/c_out=0; busy=0, done=0, pass=0; table_out=8'h00; mismatch_cnt=0.
  - Assertion mid-sweep aborts the sweep immediately. No partial result is retained.
- Outputs: all outputs are registered or decoded from registered state only. No combinational path from x_in or start to any output.
- Vector drive:
  - {a_out,b_out,c_out} = idx while in SETTLE or SAMPLE.
  - {a_out,b_out,c_out} = 3'b000 in IDLE and DONE.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 -> accept.
  - On accept: idx<=0, settle counter<=0, table_out<=0, mismatch_cnt<=0, done<=0, pass<=0.
  - Go to SETTLE; busy goes to 1 on the same edge.
- SETTLE:
  - Settle counter increments each cycle.
  - When counter == SETTLE-1, go to SAMPLE on the next edge.
  - The vector is therefore held SETTLE cycles before the sample cycle.
- SAMPLE (one cycle):
  - table_out[idx] <= x_in.
  - If x_in != EXPECTED[idx], mismatch_cnt <= mismatch_cnt+1.
  - If idx==7: go to DONE.
  - Else: idx <= idx+1, settle counter <= 0, go to SETTLE.
- DONE:
  - busy=0, done=1.
  - pass=1 iff the final mismatch_cnt==0. pass is registered on the DONE-entry edge and accounts for the idx-7 comparison.
  - table_out and mismatch_cnt hold.
  - start=1 in DONE is accepted exactly as in IDLE and restarts the sweep, clearing done/pass/table_out/mismatch_cnt.
- Latency:
  - Each vector occupies SETTLE+1 cycles.
  - The accepting edge plus 8*(SETTLE+1) further edges lands in DONE: 24 cycles after acceptance for SETTLE=2.
- Boundaries:
  - start while busy=1 is ignored; the sweep is not restarted.
  - start held high continuously re-triggers only from IDLE/DONE. A held start restarts immediately after each DONE entry, so done pulses for one cycle per sweep.
  - idx does not wrap past 7 within a sweep.
  - mismatch_cnt saturates naturally at 8, which fits in 4 bits.
  - SETTLE=1: SETTLE lasts one cycle per vector.

Test Plan:
- Reset check: assert rst with no clk edge -> all outputs 0 immediately; after release with start=0 for 10 cycles -> outputs unchanged.
- Correct DUT: connect the real x = (~a&~b)|~c, pulse start for 1 cycle, SETTLE=2 -> vectors 0..7 each held 3 cycles; done=1 exactly 24 cycles after the start edge; table_out=8'h57, mismatch_cnt=0, pass=1, busy=0.
- Faulty DUT: tie x_in=1 -> table_out=8'hFF, mismatch_cnt=3 (vectors 3, 5, 7), pass=0, done=1.
- Start during sweep: pulse start again at cycle 10 of a sweep -> no restart; done still at cycle 24; result identical to the correct-DUT case.
- Reset mid-sweep: assert rst at cycle 12 -> immediate IDLE, table_out=0, busy=0, vector=000; a new start afterwards completes normally with table_out=8'h57.
- Restart from DONE with SETTLE=1: after completion, pulse start -> done and pass drop on the next edge; new sweep completes 16 cycles after acceptance with pass=1.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// Drives all eight {a,b,c} vectors into a 3-input boolean block, samples x after
// SETTLE cycles per vector, and compares the captured truth table against EXPECTED.
module truth_table_sweeper #(
   parameter logic [7:0]  EXPECTED = 8'h57,
   parameter int unsigned SETTLE   = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       x_in,
   output logic       a_out,
   output logic       b_out,
   output logic       c_out,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [7:0] table_out,
   output logic [3:0] mismatch_cnt
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_SAMPLE,
      S_DONE
   } state_t;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

   state_t     state_q, state_d;
   logic [2:0] idx_q, idx_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] table_q, table_d;
   logic [3:0] mism_q, mism_d;
   logic       pass_q, pass_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         table_q <= '0;
         mism_q  <= '0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         table_q <= table_d;
         mism_q  <= mism_d;
         pass_q  <= pass_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      table_d = table_q;
      mism_d  = mism_q;
      pass_d  = pass_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_SETTLE;
               idx_d   = '0;
               cnt_d   = '0;
               table_d = '0;
               mism_d  = '0;
               pass_d  = 1'b0;
            end
         end
         S_SETTLE: begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == SETTLE_LAST) begin
               state_d = S_SAMPLE;
            end
         end
         S_SAMPLE: begin
            table_d[idx_q] = x_in;
            if (x_in != EXPECTED[idx_q]) begin
               mism_d = mism_q + 4'd1;
            end
            if (idx_q == 3'd7) begin
               state_d = S_DONE;
               // pass must include the final vector's comparison, so use mism_d
               pass_d  = (mism_d == 4'd0);
            end else begin
               state_d = S_SETTLE;
               idx_d   = idx_q + 3'd1;
               cnt_d   = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy                  = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
   assign done                  = (state_q == S_DONE);
   assign pass                  = pass_q;
   assign {a_out, b_out, c_out} = busy ? idx_q : 3'b000;
   assign table_out             = table_q;
   assign mismatch_cnt          = mism_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench for truth_table_sweeper: two instances (SETTLE=2 and SETTLE=1)
// driven through a table of function-block behaviours plus hand-written corner sequences.
module tb_truth_table_sweeper;

   typedef struct packed {
      logic [2:0] vec;
      logic       busy;
      logic       done;
      logic       pass;
      logic [7:0] tbl;
      logic [3:0] mc;
   } obs_t;

   typedef struct {
      logic [7:0] tbl;
      logic [3:0] mc;
      logic       pass;
   } res_t;

   typedef struct {
      int         sel;
      int         mode;
      logic [7:0] tbl;
      logic [3:0] mc;
      logic       pass;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start0 = 1'b0, start1 = 1'b0;
   logic a0, b0, c0, busy0, done0, pass0;
   logic a1, b1, c1, busy1, done1, pass1;
   logic [7:0] tbl0, tbl1;
   logic [3:0] mc0, mc1;
   logic x0, x1;
   int   mode = 0;
   int   errors = 0;
   int   checks = 0;
   res_t sb[$];
   vec_t vecs[7];
   obs_t obs0, obs1;

   always #5 clk = ~clk;

   // 0: reference function, 1: tied high, 2: tied low, 3: inverted function
   function automatic logic xfun(input int m, input logic a, input logic b, input logic c);
      logic f;
      f = (~a & ~b) | ~c;
      case (m)
         1:       return 1'b1;
         2:       return 1'b0;
         3:       return ~f;
         default: return f;
      endcase
   endfunction

   assign x0 = xfun(mode, a0, b0, c0);
   assign x1 = xfun(mode, a1, b1, c1);
   assign obs0 = '{vec: {a0, b0, c0}, busy: busy0, done: done0, pass: pass0, tbl: tbl0, mc: mc0};
   assign obs1 = '{vec: {a1, b1, c1}, busy: busy1, done: done1, pass: pass1, tbl: tbl1, mc: mc1};

   truth_table_sweeper #(.EXPECTED(8'h57), .SETTLE(2)) dut0 (
      .clk(clk), .rst(rst), .start(start0), .x_in(x0),
      .a_out(a0), .b_out(b0), .c_out(c0),
      .busy(busy0), .done(done0), .pass(pass0),
      .table_out(tbl0), .mismatch_cnt(mc0)
   );

   truth_table_sweeper #(.EXPECTED(8'h57), .SETTLE(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .x_in(x1),
      .a_out(a1), .b_out(b1), .c_out(c1),
      .busy(busy1), .done(done1), .pass(pass1),
      .table_out(tbl1), .mismatch_cnt(mc1)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
      end
   endtask

   function automatic obs_t get_obs(input int sel);
      return (sel == 0) ? obs0 : obs1;
   endfunction

   task automatic set_start(input int sel, input logic v);
      if (sel == 0) start0 = v;
      else          start1 = v;
   endtask

   // One full sweep; extra_at >= 0 pulses start again that many edges after acceptance.
   task automatic run_sweep(input int sel, input int per, input logic [7:0] tbl,
                            input logic [3:0] mc, input logic ps, input int extra_at);
      obs_t o;
      res_t r;
      sb.push_back('{tbl: tbl, mc: mc, pass: ps});
      @(negedge clk);
      set_start(sel, 1'b1);
      @(negedge clk);
      set_start(sel, 1'b0);
      o = get_obs(sel);
      chk("accept_clear", {o.done, o.pass, o.tbl, o.mc}, 14'd0);
      for (int k = 0; k < 8 * per; k++) begin
         o = get_obs(sel);
         chk("vector", {o.busy, o.done, o.vec}, {1'b1, 1'b0, 3'(k / per)});
         set_start(sel, (k == extra_at));
         @(negedge clk);
      end
      set_start(sel, 1'b0);
      o = get_obs(sel);
      chk("done_state", {o.busy, o.done, o.vec}, {1'b0, 1'b1, 3'b000});
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 32'd1, 32'd0);
      end else begin
         r = sb.pop_front();
         chk("table_out", o.tbl, r.tbl);
         chk("mismatch_cnt", o.mc, r.mc);
         chk("pass", o.pass, r.pass);
      end
   endtask

   initial begin
      vecs[0] = '{sel: 0, mode: 0, tbl: 8'h57, mc: 4'd0, pass: 1'b1};
      vecs[1] = '{sel: 0, mode: 1, tbl: 8'hFF, mc: 4'd3, pass: 1'b0};
      vecs[2] = '{sel: 0, mode: 2, tbl: 8'h00, mc: 4'd5, pass: 1'b0};
      vecs[3] = '{sel: 0, mode: 3, tbl: 8'hA8, mc: 4'd8, pass: 1'b0};
      vecs[4] = '{sel: 1, mode: 0, tbl: 8'h57, mc: 4'd0, pass: 1'b1};
      vecs[5] = '{sel: 1, mode: 1, tbl: 8'hFF, mc: 4'd3, pass: 1'b0};
      vecs[6] = '{sel: 1, mode: 0, tbl: 8'h57, mc: 4'd0, pass: 1'b1};

      // Reset: outputs zero with no clock edge, then stay put with start low
      #2;
      chk("reset_async0", obs0, '0);
      chk("reset_async1", obs1, '0);
      @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      chk("idle_hold0", obs0, '0);
      chk("idle_hold1", obs1, '0);

      foreach (vecs[i]) begin
         mode = vecs[i].mode;
         run_sweep(vecs[i].sel, (vecs[i].sel == 0) ? 3 : 2,
                   vecs[i].tbl, vecs[i].mc, vecs[i].pass, -1);
      end

      // start during a sweep is ignored
      mode = 0;
      run_sweep(0, 3, 8'h57, 4'd0, 1'b1, 10);

      // Reset mid-sweep aborts without keeping the partial table
      @(negedge clk);
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      repeat (12) @(negedge clk);
      chk("pre_abort_partial", (tbl0 != 8'h00), 1'b1);
      #1 rst = 1'b1;
      #1;
      chk("abort_state", obs0, '0);
      @(negedge clk);
      rst = 1'b0;
      run_sweep(0, 3, 8'h57, 4'd0, 1'b1, -1);

      // Held start: done lasts one cycle, then the sweep restarts
      @(negedge clk);
      start0 = 1'b1;
      repeat (25) @(negedge clk);
      chk("held_done", {busy0, done0, pass0}, 3'b011);
      @(negedge clk);
      chk("held_restart", {busy0, done0, pass0, tbl0}, 11'b100_00000000);
      start0 = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
